// File: rtl/button_event_arbiter.sv
// Latches debounced press pulses as pending events and serves them one at a time
// over valid/ready, round-robin, with a cooldown after every accepted event.
module button_event_arbiter #(
   parameter int unsigned NUM_BTN  = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned COOLDOWN = 1000000,
   parameter int unsigned DROP_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btnPulse,
   input  logic               enable,
   input  logic               evtReady,
   input  logic               clearDrops,
   output logic               evtValid,
   output logic [ID_W-1:0]    evtId,
   output logic [NUM_BTN-1:0] pendingMask,
   output logic [DROP_W-1:0]  dropCount,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESENT,
      ST_COOLDOWN
   } state_e;

   localparam logic [19:0]       CD_LOAD  = (COOLDOWN == 0) ? 20'd0 : 20'(COOLDOWN - 1);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;
   localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_BTN - 1);

   state_e               state_q, state_d;
   logic [NUM_BTN-1:0]   pending_q, pending_d;
   logic [DROP_W-1:0]    drop_q, drop_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      evt_id_q, evt_id_d;
   logic                 evt_valid_q, evt_valid_d;
   logic                 busy_q, busy_d;
   logic [19:0]          cnt_q, cnt_d;

   logic [NUM_BTN-1:0]   grant_vec;
   logic [ID_W-1:0]      grant_id;
   logic                 grant_found;
   logic                 drop_hit;

   // Round-robin scan of the registered pending bits, starting at rr_ptr_q.
   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      grant_vec   = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      sum         = '0;
      idx         = '0;
      if (state_q == ST_IDLE && enable) begin
         for (int unsigned off = 0; off < NUM_BTN; off++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(NUM_BTN)) begin
               sum = sum - (ID_W+1)'(NUM_BTN);
            end
            idx = sum[ID_W-1:0];
            if (!grant_found && pending_q[idx]) begin
               grant_found    = 1'b1;
               grant_id       = idx;
               grant_vec[idx] = 1'b1;
            end
         end
      end
   end

   // A pulse landing on the bit being granted re-arms it rather than counting as a drop.
   always_comb begin
      pending_d = (pending_q & ~grant_vec) | btnPulse;
      drop_hit  = |(btnPulse & pending_q & ~grant_vec);
      drop_d    = drop_q;
      if (clearDrops) begin
         drop_d = '0;
      end else if (drop_hit && drop_q != DROP_MAX) begin
         drop_d = drop_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      evt_valid_d = evt_valid_q;
      evt_id_d    = evt_id_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               evt_valid_d = 1'b1;
               evt_id_d    = grant_id;
               state_d     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (evtReady) begin
               evt_valid_d = 1'b0;
               rr_ptr_d    = (evt_id_q == LAST_ID) ? '0 : evt_id_q + 1'b1;
               if (COOLDOWN == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_COOLDOWN;
                  cnt_d   = CD_LOAD;
               end
            end
         end
         ST_COOLDOWN: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         drop_q      <= '0;
         rr_ptr_q    <= '0;
         evt_id_q    <= '0;
         evt_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         pending_q   <= pending_d;
         drop_q      <= drop_d;
         rr_ptr_q    <= rr_ptr_d;
         evt_id_q    <= evt_id_d;
         evt_valid_q <= evt_valid_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   assign evtValid    = evt_valid_q;
   assign evtId       = evt_id_q;
   assign pendingMask = pending_q;
   assign dropCount   = drop_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench: one arbiter with a 3-cycle cooldown and one with none, fed the same stimulus.
module tb_button_event_arbiter;

   logic       clock;
   logic       reset;
   logic [3:0] btnPulse;
   logic       enable;
   logic       evtReady;
   logic       clearDrops;

   logic       cd_valid, nc_valid;
   logic [1:0] cd_id, nc_id;
   logic [3:0] cd_pend, nc_pend;
   logic [7:0] cd_drop, nc_drop;
   logic       cd_busy, nc_busy;

   int checks   = 0;
   int failures = 0;

   button_event_arbiter #(.NUM_BTN(4), .ID_W(2), .COOLDOWN(3), .DROP_W(8)) dut_cd (
      .clock(clock), .reset(reset), .btnPulse(btnPulse), .enable(enable),
      .evtReady(evtReady), .clearDrops(clearDrops), .evtValid(cd_valid),
      .evtId(cd_id), .pendingMask(cd_pend), .dropCount(cd_drop), .busy(cd_busy)
   );

   button_event_arbiter #(.NUM_BTN(4), .ID_W(2), .COOLDOWN(0), .DROP_W(8)) dut_nc (
      .clock(clock), .reset(reset), .btnPulse(btnPulse), .enable(enable),
      .evtReady(evtReady), .clearDrops(clearDrops), .evtValid(nc_valid),
      .evtId(nc_id), .pendingMask(nc_pend), .dropCount(nc_drop), .busy(nc_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      btnPulse   = '0;
      enable     = 1'b1;
      evtReady   = 1'b1;
      clearDrops = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      do_reset();
      check("rst_valid", 32'(cd_valid), 0);
      check("rst_id",    32'(cd_id),    0);
      check("rst_pend",  32'(cd_pend),  0);
      check("rst_drop",  32'(cd_drop),  0);
      check("rst_busy",  32'(cd_busy),  0);
      check("rst_nc_busy", 32'(nc_busy), 0);

      // Single press, cooldown 3, consumer always ready
      btnPulse = 4'b0010;
      tick();
      btnPulse = '0;
      check("t1_pend",   32'(cd_pend),  4'b0010);
      check("t1_valid0", 32'(cd_valid), 0);
      tick();
      check("t1_valid1", 32'(cd_valid), 1);
      check("t1_id",     32'(cd_id),    1);
      check("t1_busy_p", 32'(cd_busy),  1);
      check("t1_pend0",  32'(cd_pend),  0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t1_cd_valid", 32'(cd_valid), 0);
         check("t1_cd_busy",  32'(cd_busy),  1);
      end
      tick();
      check("t1_idle_busy", 32'(cd_busy), 0);

      // Round-robin order on the no-cooldown instance
      do_reset();
      btnPulse = 4'b0101;
      tick();
      btnPulse = '0;
      check("t2_pend", 32'(nc_pend), 4'b0101);
      tick();
      check("t2_a_valid", 32'(nc_valid), 1);
      check("t2_a_id",    32'(nc_id),    0);
      tick();
      check("t2_gap_valid", 32'(nc_valid), 0);
      check("t2_gap_pend",  32'(nc_pend),  4'b0100);
      tick();
      check("t2_b_valid", 32'(nc_valid), 1);
      check("t2_b_id",    32'(nc_id),    2);
      tick();
      btnPulse = 4'b0001;
      tick();
      btnPulse = '0;
      tick();
      check("t2_c_valid", 32'(nc_valid), 1);
      check("t2_c_id",    32'(nc_id),    0);
      tick();
      btnPulse = 4'b0101;
      tick();
      btnPulse = '0;
      tick();
      check("t2_d_valid", 32'(nc_valid), 1);
      check("t2_d_id",    32'(nc_id),    2);
      tick();
      tick();
      check("t2_e_valid", 32'(nc_valid), 1);
      check("t2_e_id",    32'(nc_id),    0);

      // Back-pressure: presented event must hold until accepted
      do_reset();
      evtReady = 1'b0;
      btnPulse = 4'b0100;
      tick();
      btnPulse = '0;
      tick();
      for (int c = 0; c < 20; c++) begin
         tick();
         check("t3_hold_valid", 32'(cd_valid), 1);
         check("t3_hold_id",    32'(cd_id),    2);
      end
      evtReady = 1'b1;
      tick();
      evtReady = 1'b0;
      check("t3_accept_valid", 32'(cd_valid), 0);
      check("t3_accept_busy",  32'(cd_busy),  1);
      repeat (4) tick();
      check("t3_after_valid", 32'(cd_valid), 0);
      check("t3_after_busy",  32'(cd_busy),  0);

      // Drop counting, saturation and clear priority (grants disabled)
      do_reset();
      enable   = 1'b0;
      btnPulse = 4'b1000;
      tick();
      check("t4_first_drop", 32'(cd_drop), 0);
      tick();
      check("t4_one_drop", 32'(cd_drop), 1);
      check("t4_pend",     32'(cd_pend), 4'b1000);
      repeat (299) tick();
      check("t4_saturated", 32'(cd_drop), 255);
      clearDrops = 1'b1;
      tick();
      clearDrops = 1'b0;
      check("t4_clear", 32'(cd_drop), 0);
      btnPulse = 4'b0001;
      tick();
      check("t4_new_bit", 32'(cd_drop), 0);
      btnPulse = 4'b1001;
      tick();
      btnPulse = '0;
      check("t4_multi_drop", 32'(cd_drop), 1);
      check("t4_multi_pend", 32'(cd_pend), 4'b1001);

      // Enable gating, plus a pulse on the bit granted in the same edge
      do_reset();
      enable   = 1'b0;
      evtReady = 1'b0;
      btnPulse = 4'b0011;
      tick();
      btnPulse = '0;
      check("t5_pend", 32'(cd_pend), 4'b0011);
      repeat (2) begin
         tick();
         check("t5_no_grant", 32'(cd_valid), 0);
      end
      enable   = 1'b1;
      btnPulse = 4'b0001;
      tick();
      btnPulse = '0;
      check("t5_valid", 32'(cd_valid), 1);
      check("t5_id",    32'(cd_id),    0);
      check("t5_pend2", 32'(cd_pend),  4'b0011);
      check("t5_drop",  32'(cd_drop),  0);

      // Asynchronous reset while presenting
      do_reset();
      enable   = 1'b0;
      evtReady = 1'b0;
      btnPulse = 4'b0111;
      tick();
      tick();
      btnPulse = '0;
      enable   = 1'b1;
      tick();
      check("t6_pre_valid", 32'(cd_valid), 1);
      check("t6_pre_pend",  32'(cd_pend),  4'b0110);
      check("t6_pre_drop",  32'(cd_drop),  1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_valid", 32'(cd_valid), 0);
      check("t6_rst_pend",  32'(cd_pend),  0);
      check("t6_rst_drop",  32'(cd_drop),  0);
      check("t6_rst_busy",  32'(cd_busy),  0);
      #2;
      reset    = 1'b1;
      evtReady = 1'b1;
      repeat (5) tick();
      check("t6_quiet_valid", 32'(cd_valid), 0);
      check("t6_quiet_pend",  32'(cd_pend),  0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
